// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment display scan path.
//   scan_state_t : scan controller FSM states
//   SEG_*        : gfedcba segment patterns, active high, bit 0 = segment a
//   DIGIT_IDX_W  : width of the digit index handed to clock_to_bcd
package display_scan_ctrl_pkg;

  localparam int unsigned DIGIT_IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LATCH,
    ON,
    BLANK
  } scan_state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/display_scan_ctrl_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder.
//   bcd      : 4-bit BCD digit; codes 10..15 are invalid
//   segments : active-high gfedcba pattern; invalid codes give all segments off
module bcd_to_7seg
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (bcd)
      4'd0:    segments = SEG_0;
      4'd1:    segments = SEG_1;
      4'd2:    segments = SEG_2;
      4'd3:    segments = SEG_3;
      4'd4:    segments = SEG_4;
      4'd5:    segments = SEG_5;
      4'd6:    segments = SEG_6;
      4'd7:    segments = SEG_7;
      4'd8:    segments = SEG_8;
      4'd9:    segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the 6-digit HH:MM:SS 7-segment display.
// Steps the digit selector of clock_to_bcd, captures the returned digit, and
// drives one-hot digit enables with per-digit PWM brightness plus a blank gap
// between digits. All outputs are registered.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_en             : scan enable; low forces IDLE with all outputs off
//   i_refresh_stb    : one-cycle refresh tick pacing the ON/BLANK windows
//   i_brightness     : on for (i_brightness+1)/ON_TICKS of each ON window,
//                      sampled only at frame boundaries
//   i_lzb            : blank a leading zero on digit 0
//   i_bcd, i_dp      : digit and decimal point for the current o_seg_select
//   o_seg_select     : digit index to clock_to_bcd
//   o_segments, o_dp : active-high segments (gfedcba) and decimal point
//   o_digit_en       : one-hot active-high digit enable
//   o_frame_done     : one-cycle pulse after the last digit's blank window
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned ON_TICKS    = 8,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_en,
  input  logic                   i_refresh_stb,
  input  logic [2:0]             i_brightness,
  input  logic                   i_lzb,
  input  logic [3:0]             i_bcd,
  input  logic                   i_dp,
  output logic [DIGIT_IDX_W-1:0] o_seg_select,
  output logic [6:0]             o_segments,
  output logic                   o_dp,
  output logic [NUM_DIGITS-1:0]  o_digit_en,
  output logic                   o_frame_done
);

  localparam int unsigned MAX_TICKS = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  // Counter is at least 3 bits so the brightness code compares without truncation.
  localparam int unsigned CNT_W = ($clog2(MAX_TICKS + 1) > 3) ? $clog2(MAX_TICKS + 1) : 3;
  localparam logic [CNT_W-1:0]       ON_LAST    = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0]       BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [DIGIT_IDX_W-1:0] LAST_DIGIT = DIGIT_IDX_W'(NUM_DIGITS - 1);

  scan_state_t            state_r, state_n;
  logic [DIGIT_IDX_W-1:0] digit_r, digit_n;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [2:0]             bright_r, bright_n;
  logic [DIGIT_IDX_W-1:0] sel_n;
  logic [6:0]             seg_n;
  logic                   dp_n;
  logic [NUM_DIGITS-1:0]  en_n;
  logic                   fd_n;

  logic [6:0]            dec_seg;
  logic                  lz_blank;
  logic [NUM_DIGITS-1:0] digit_onehot;
  logic [CNT_W-1:0]      bright_ext;

  bcd_to_7seg u_dec (
    .bcd      (i_bcd),
    .segments (dec_seg)
  );

  assign lz_blank     = i_lzb && (digit_r == '0) && (i_bcd == 4'd0);
  assign digit_onehot = NUM_DIGITS'(1) << digit_r;
  assign bright_ext   = CNT_W'(bright_r);

  always_comb begin
    state_n  = state_r;
    digit_n  = digit_r;
    cnt_n    = cnt_r;
    bright_n = bright_r;
    sel_n    = o_seg_select;
    seg_n    = o_segments;
    dp_n     = o_dp;
    en_n     = '0;
    fd_n     = 1'b0;

    if (!i_en) begin
      state_n = IDLE;
      digit_n = '0;
      cnt_n   = '0;
      sel_n   = '0;
      seg_n   = SEG_BLANK;
      dp_n    = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          digit_n = '0;
          cnt_n   = '0;
          sel_n   = '0;
          seg_n   = SEG_BLANK;
          dp_n    = 1'b0;
          if (i_refresh_stb) begin
            bright_n = i_brightness;
            state_n  = SELECT;
          end
        end

        SELECT: begin
          sel_n   = digit_r;
          state_n = LATCH;
        end

        LATCH: begin
          seg_n   = lz_blank ? SEG_BLANK : dec_seg;
          dp_n    = i_dp;
          cnt_n   = '0;
          en_n    = digit_onehot;
          state_n = ON;
        end

        ON: begin
          // The enable register tracks the count it will hold next cycle,
          // so the PWM edge lines up with the strobe that moves the count.
          en_n = (cnt_r <= bright_ext) ? digit_onehot : '0;
          if (i_refresh_stb) begin
            if (cnt_r == ON_LAST) begin
              cnt_n   = '0;
              en_n    = '0;
              seg_n   = SEG_BLANK;
              dp_n    = 1'b0;
              state_n = BLANK;
            end else begin
              cnt_n = cnt_r + 1'b1;
              en_n  = (cnt_n <= bright_ext) ? digit_onehot : '0;
            end
          end
        end

        BLANK: begin
          seg_n = SEG_BLANK;
          dp_n  = 1'b0;
          if (i_refresh_stb) begin
            if (cnt_r == BLANK_LAST) begin
              cnt_n   = '0;
              state_n = SELECT;
              if (digit_r < LAST_DIGIT) begin
                digit_n = digit_r + 1'b1;
              end else begin
                digit_n  = '0;
                fd_n     = 1'b1;
                bright_n = i_brightness;
              end
            end else begin
              cnt_n = cnt_r + 1'b1;
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r      <= IDLE;
      digit_r      <= '0;
      cnt_r        <= '0;
      bright_r     <= '0;
      o_seg_select <= '0;
      o_segments   <= '0;
      o_dp         <= 1'b0;
      o_digit_en   <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state_r      <= state_n;
      digit_r      <= digit_n;
      cnt_r        <= cnt_n;
      bright_r     <= bright_n;
      o_seg_select <= sel_n;
      o_segments   <= seg_n;
      o_dp         <= dp_n;
      o_digit_en   <= en_n;
      o_frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       stb;
  logic [2:0] bright;
  logic       lzb;
  logic [3:0] bcd;
  logic       dp;
  logic [3:0] sel;
  logic [6:0] segs;
  logic       dpo;
  logic [5:0] den;
  logic       fd;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS  (6),
    .ON_TICKS    (8),
    .BLANK_TICKS (1)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_en          (en),
    .i_refresh_stb (stb),
    .i_brightness  (bright),
    .i_lzb         (lzb),
    .i_bcd         (bcd),
    .i_dp          (dp),
    .o_seg_select  (sel),
    .o_segments    (segs),
    .o_dp          (dpo),
    .o_digit_en    (den),
    .o_frame_done  (fd)
  );

  // clock_to_bcd model: digit and dp are a combinational function of sel
  logic [3:0] t_digits [6];
  logic [5:0] t_dpmask;
  logic       force_on;
  logic [3:0] force_idx;
  logic [3:0] force_bcd;
  logic       force_dp;

  always_comb begin
    bcd = 4'hF;
    dp  = 1'b0;
    if (sel < 4'd6) begin
      bcd = t_digits[int'(sel)];
      dp  = t_dpmask[int'(sel)];
    end
    if (force_on && sel == force_idx) begin
      bcd = force_bcd;
      dp  = force_dp;
    end
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int d);
    logic [3:0] v;
    v = (force_on && force_idx == 4'(d)) ? force_bcd : t_digits[d];
    if (lzb && d == 0 && v == 4'd0) return 7'b0000000;
    return ref_seg(v);
  endfunction

  function automatic logic exp_dp(input int d);
    if (force_on && force_idx == 4'(d)) return force_dp;
    return t_dpmask[d];
  endfunction

  typedef struct {
    int         id;
    logic [5:0] en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    logic       fd;
  } exp_t;

  exp_t       exp_q[$];
  int         checks     = 0;
  int         failures   = 0;
  int         step_id    = 0;
  int         fd_count   = 0;
  int         exp_frames = 0;
  logic [3:0] prev_sel   = '0;

  // Scoreboard: pop one expectation per pushed step, compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      assert (den === e.en) else begin
        failures++;
        $error("FAIL digit_en step %0d: got %b want %b", e.id, den, e.en);
      end
      checks++;
      assert (segs === e.seg) else begin
        failures++;
        $error("FAIL segments step %0d: got %b want %b", e.id, segs, e.seg);
      end
      checks++;
      assert (dpo === e.dp) else begin
        failures++;
        $error("FAIL dp step %0d: got %b want %b", e.id, dpo, e.dp);
      end
      checks++;
      assert (sel === e.sel) else begin
        failures++;
        $error("FAIL seg_select step %0d: got %0d want %0d", e.id, sel, e.sel);
      end
      checks++;
      assert (fd === e.fd) else begin
        failures++;
        $error("FAIL frame_done step %0d: got %b want %b", e.id, fd, e.fd);
      end
    end
  end

  // Continuous invariants: one-hot-or-zero enables, dark display on select change.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ($onehot0(den)) else begin
        failures++;
        $error("FAIL onehot0 at %0t: got %b want at most one bit", $time, den);
      end
    end
    if (sel !== prev_sel) begin
      checks++;
      assert (den === 6'b0 && segs === 7'b0) else begin
        failures++;
        $error("FAIL dark_on_select at %0t: got en=%b seg=%b want 0/0", $time, den, segs);
      end
    end
    if (fd === 1'b1) fd_count++;
    prev_sel <= sel;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic observe(input logic [5:0] e_en, input logic [6:0] e_seg, input logic e_dp,
                         input logic [3:0] e_sel, input logic e_fd);
    exp_t e;
    e.id  = step_id;
    e.en  = e_en;
    e.seg = e_seg;
    e.dp  = e_dp;
    e.sel = e_sel;
    e.fd  = e_fd;
    step_id++;
    exp_q.push_back(e);
    cyc(1);
  endtask

  task automatic strobe();
    stb = 1'b1;
    cyc(1);
    stb = 1'b0;
  endtask

  task automatic start_scan();
    strobe();
    observe(6'b0, 7'b0, 1'b0, 4'd0, 1'b0);
    cyc(1);
  endtask

  // One digit: 8 ON strobes then 1 BLANK strobe, observing before and after each.
  task automatic run_digit(input int d, input int br, input bit last);
    logic [6:0] s;
    logic       p;
    logic [5:0] oh;
    s  = exp_seg(d);
    p  = exp_dp(d);
    oh = 6'b1 << d;
    for (int k = 0; k < 8; k++) begin
      observe((k <= br) ? oh : 6'b0, s, p, 4'(d), 1'b0);
      strobe();
      if (k + 1 < 8) observe((k + 1 <= br) ? oh : 6'b0, s, p, 4'(d), 1'b0);
      else           observe(6'b0, 7'b0, 1'b0, 4'(d), 1'b0);
      cyc(1);
    end
    observe(6'b0, 7'b0, 1'b0, 4'(d), 1'b0);
    strobe();
    observe(6'b0, 7'b0, 1'b0, 4'(d), last);
    if (last) exp_frames++;
    cyc(1);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    stb       = 1'b0;
    bright    = 3'd7;
    lzb       = 1'b0;
    force_on  = 1'b0;
    force_idx = 4'd0;
    force_bcd = 4'd0;
    force_dp  = 1'b0;
    t_digits  = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd5, 4'd9};
    t_dpmask  = 6'b001010;
    cyc(2);
    observe(6'b0, 7'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    cyc(1);
    en = 1'b1;
    cyc(3);
    observe(6'b0, 7'b0, 1'b0, 4'd0, 1'b0);

    // Frame 1: 12:30:59 full brightness; brightness change mid-frame is deferred.
    start_scan();
    for (int d = 0; d < 6; d++) begin
      run_digit(d, 7, d == 5);
      if (d == 2) bright = 3'd2;
    end
    // Frame 2: free-running at brightness 2; change to 5 mid-frame.
    for (int d = 0; d < 6; d++) begin
      run_digit(d, 2, d == 5);
      if (d == 1) bright = 3'd5;
    end
    // Frame 3: brightness 5, enable dropped during digit 4 ON.
    for (int d = 0; d < 4; d++) run_digit(d, 5, 1'b0);
    observe(6'b010000, exp_seg(4), exp_dp(4), 4'd4, 1'b0);
    strobe();
    cyc(2);
    observe(6'b010000, exp_seg(4), exp_dp(4), 4'd4, 1'b0);
    en = 1'b0;
    cyc(1);
    observe(6'b0, 7'b0, 1'b0, 4'd0, 1'b0);

    // Frame 4: 05:00:00 with leading-zero blank, invalid code plus dp on digit 3.
    t_digits  = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    lzb       = 1'b1;
    force_on  = 1'b1;
    force_idx = 4'd3;
    force_bcd = 4'hC;
    force_dp  = 1'b1;
    bright    = 3'd7;
    cyc(2);
    observe(6'b0, 7'b0, 1'b0, 4'd0, 1'b0);
    en = 1'b1;
    cyc(1);
    start_scan();
    for (int d = 0; d < 6; d++) begin
      run_digit(d, 7, d == 5);
      if (d == 0) lzb = 1'b0;
    end
    // Frame 5: leading zero now shown; reset asserted mid-ON of digit 2.
    force_on = 1'b0;
    run_digit(0, 7, 1'b0);
    run_digit(1, 7, 1'b0);
    observe(6'b000100, exp_seg(2), exp_dp(2), 4'd2, 1'b0);
    strobe();
    cyc(2);
    rst_n = 1'b0;
    observe(6'b0, 7'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    cyc(4);
    observe(6'b0, 7'b0, 1'b0, 4'd0, 1'b0);
    start_scan();
    run_digit(0, 7, 1'b0);
    cyc(2);

    checks++;
    assert (fd_count == exp_frames) else begin
      failures++;
      $error("FAIL frame_done_count: got %0d want %0d", fd_count, exp_frames);
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the 6-digit HH:MM:SS 7-segment display. It sequences the digit selector of clock_to_bcd from 0 to 5 and captures the returned BCD digit and decimal point. It decodes the digit to segments and drives one-hot digit enables with per-digit PWM brightness and an anti-ghosting blank interval. It sits between clock_to_bcd and the top-level output pins, paced by a refresh strobe from the system divider.

Parameters:
NUM_DIGITS, 6, digits scanned per frame (index 0 = hours MSD, 5 = seconds LSD)
ON_TICKS, 8, refresh strobes per digit ON window (PWM period)
BLANK_TICKS, 1, refresh strobes with all digits off between digits

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_en  input  1  scan enable
i_refresh_stb  input  1  one-cycle refresh tick
i_brightness  input  3  0..7 → on for (i_brightness+1)/8 of each ON window
i_lzb  input  1  leading-zero blank for digit 0
i_bcd  input  4  BCD digit from clock_to_bcd (combinational function of o_seg_select)
i_dp  input  1  decimal point from clock_to_bcd
o_seg_select  output  4  digit index to clock_to_bcd
o_segments  output  7  active-high segments; [0]=a … [6]=g
o_dp  output  1  active-high decimal point
o_digit_en  output  6  one-hot active-high digit enable
o_frame_done  output  1  one-cycle pulse after the last digit's BLANK

Behaviour:
- Reset (async assert, sync release): state IDLE. o_seg_select=0, o_segments=0, o_dp=0, o_digit_en=0, o_frame_done=0. Digit index, strobe counter and brightness register all 0.
- All outputs are registered.
- FSM states: IDLE, SELECT, LATCH, ON, BLANK.
- IDLE: all outputs 0. When i_en && i_refresh_stb: set digit=0, sample i_brightness into bright_r, go to SELECT.
- SELECT (1 cycle): o_seg_select <= digit. Go to LATCH.
- LATCH (1 cycle): i_bcd/i_dp are now valid for the registered o_seg_select. Capture the decoded segments and i_dp into the output registers. Clear the strobe counter. Go to ON.
- ON: o_digit_en = one-hot(digit) while strobe count <= bright_r, else 0. Segments and dp are held. Each i_refresh_stb increments the count. On the ON_TICKS-th strobe: clear count, go to BLANK.
- BLANK: o_digit_en=0, o_segments=0, o_dp=0. On the BLANK_TICKS-th strobe:
  - if digit < NUM_DIGITS-1: digit+1, go to SELECT.
  - else: pulse o_frame_done for 1 cycle, digit=0, resample bright_r, go to SELECT.
- Strobes arriving during SELECT/LATCH are ignored. Strobes are not counted in IDLE.
- Decode, gfedcba order: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- BCD 10..15 decodes to 0000000; dp still passes through.
- Leading-zero blank: if i_lzb && digit==0 && i_bcd==0, segments = 0000000. dp is unaffected.
- i_en deasserted in any state: next cycle go to IDLE, all outputs 0, digit=0. No frame_done is emitted.
- i_brightness is changed only at frame boundaries (sampled into bright_r), so there is no mid-frame flicker.
- i_en held high continuously gives a free-running scan with no IDLE gap.
- At most one digit_en bit is high at any time.
- o_digit_en and o_segments are never nonzero in the same cycle as a change of o_seg_select.

Decomposition:
- Shared package:
  - FSM state enum: IDLE, SELECT, LATCH, ON, BLANK.
  - SEG_* 7-bit decode constants and SEG_BLANK.
  - DIGIT_IDX_W = 4.
- One natural sub-module: bcd_to_7seg, a combinational 4-bit BCD → 7 segments decoder with invalid-code blanking. It is reused elsewhere in the display path.

Test Plan:
- Reset mid-ON (brightness 7, digit 2 enabled): assert i_reset_n=0 → all outputs 0 in the same cycle (async). After release, remain IDLE until the next strobe.
- 12:30:59, bench models clock_to_bcd, i_brightness=7, i_lzb=0: over one frame o_seg_select steps 0..5.
  - o_digit_en walks 000001→100000 with segments 0000110, 1011011, 1001111, 0111111, 1101101, 1101111.
  - Exactly one o_frame_done pulse after the digit-5 BLANK.
- Brightness: i_brightness=2 → in each ON window digit_en is high for exactly 3 of 8 strobe intervals.
  - Change to 5 mid-frame → no effect until after o_frame_done; the next frame shows 6/8.
- Leading-zero blank: time 05:00:00, i_lzb=1 → digit 0 segments 0000000 with digit_en still asserted; digit 1 shows 1101101.
  - With i_lzb=0, digit 0 shows 0111111.
- Invalid/dp: force i_bcd=4'hC with i_dp=1 on digit 3 → o_segments=0000000, o_dp=1 during ON; o_dp=0 during BLANK.
- Enable drop: deassert i_en during digit 4 ON → next cycle o_digit_en=0 and state IDLE. Re-enable + strobe → restart at o_seg_select=0.
